// File: rtl/fruit_pkg.sv
// Shared types, constants and fixed-point helpers for the fruit physics engine.
package fruit_pkg;

  localparam int unsigned FRAC_BITS      = 4;
  localparam int unsigned VEL_W          = 12;
  localparam int unsigned POS_W          = 11 + FRAC_BITS;
  localparam int unsigned PIX_W          = 10;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned GRAV_W         = 5;
  localparam int unsigned GRAV_BASE      = 2;
  localparam int unsigned GRAV_INC       = 1;
  localparam int unsigned CUTS_PER_LEVEL = 5;
  localparam int unsigned MAX_LEVEL      = 7;
  localparam int unsigned MAX_MISSES     = 3;
  localparam int unsigned X_MAX          = 639;
  localparam int unsigned Y_MAX          = 479;

  typedef enum logic [1:0] {StFree, StFlying, StSliced} slot_state_t;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  localparam pos_t XMaxPos = pos_t'(X_MAX);
  localparam pos_t YMaxPos = pos_t'(Y_MAX);

  // Integer pixel of a fixed-point position, clamped to 0..lim.
  function automatic logic [PIX_W-1:0] pix_clamp(pos_t p, logic [PIX_W-1:0] lim);
    pos_t i;
    i = p >>> FRAC_BITS;
    if (i[POS_W-1]) begin
      return '0;
    end else if (i > $signed({{(POS_W-PIX_W){1'b0}}, lim})) begin
      return lim;
    end else begin
      return i[PIX_W-1:0];
    end
  endfunction

  // Position plus velocity, saturated to the position range.
  function automatic pos_t sat_add_pos(pos_t p, vel_t v);
    logic signed [POS_W:0] s;
    s = {p[POS_W-1], p} + {{(POS_W+1-VEL_W){v[VEL_W-1]}}, v};
    if (s[POS_W] != s[POS_W-1]) begin
      return s[POS_W] ? {1'b1, {(POS_W-1){1'b0}}} : {1'b0, {(POS_W-1){1'b1}}};
    end
    return s[POS_W-1:0];
  endfunction

  // Velocity plus unsigned gravity, saturated to the velocity range.
  function automatic vel_t sat_add_vel(vel_t v, logic [GRAV_W-1:0] g);
    logic signed [VEL_W:0] s;
    s = {v[VEL_W-1], v} + {{(VEL_W+1-GRAV_W){1'b0}}, g};
    if (s[VEL_W] != s[VEL_W-1]) begin
      return s[VEL_W] ? {1'b1, {(VEL_W-1){1'b0}}} : {1'b0, {(VEL_W-1){1'b1}}};
    end
    return s[VEL_W-1:0];
  endfunction

endpackage

// File: rtl/fruit_slot.sv
// One fruit slot: lifecycle FSM, fixed-point position/velocity, step and exit detect.
module fruit_slot
  import fruit_pkg::*;
(
  input  logic                    frame_clk,
  input  logic                    Reset_n,
  input  logic                    load,
  input  logic [PIX_W-1:0]        load_x,
  input  logic signed [VEL_W-1:0] load_vx,
  input  logic signed [VEL_W-1:0] load_vy,
  input  logic [PIX_W-1:0]        load_size,
  input  logic                    step_en,
  input  logic                    cut,
  input  logic [GRAV_W-1:0]       gravity,
  output logic                    active,
  output logic                    sliced,
  output logic                    cut_hit,
  output logic                    miss,
  output logic [PIX_W-1:0]        x_pix,
  output logic [PIX_W-1:0]        y_pix,
  output logic [PIX_W-1:0]        size
);

  slot_state_t state_q, state_d;
  pos_t pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  vel_t vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [PIX_W-1:0] size_q, size_d;

  pos_t x_step, y_step, x_step_int, y_step_int;
  vel_t vy_step;
  logic stepping, exits, loading;

  // Step arithmetic, exit detect, FSM next state and datapath next state.
  always_comb begin
    stepping   = step_en && (state_q != StFree);
    loading    = load && (state_q == StFree);
    x_step     = sat_add_pos(pos_x_q, vel_x_q);
    y_step     = sat_add_pos(pos_y_q, vel_y_q);
    vy_step    = sat_add_vel(vel_y_q, gravity);
    x_step_int = x_step >>> FRAC_BITS;
    y_step_int = y_step >>> FRAC_BITS;
    // Bottom exit only while falling, so a fresh spawn on the bottom row survives.
    exits = stepping && (x_step[POS_W-1] || (x_step_int > XMaxPos) ||
                         ((y_step_int > YMaxPos) && !vel_y_q[VEL_W-1] && (vel_y_q != '0)));
    cut_hit = cut && (state_q == StFlying);
    miss    = exits && (state_q == StFlying) && !cut;

    state_d = state_q;
    unique case (state_q)
      StFree:   if (load) state_d = StFlying;
      StFlying: begin
        if (exits) state_d = StFree;
        else if (cut) state_d = StSliced;
      end
      StSliced: if (exits) state_d = StFree;
      default:  state_d = StFree;
    endcase

    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_x_d = vel_x_q;
    vel_y_d = vel_y_q;
    size_d  = size_q;
    if (loading) begin
      pos_x_d = pos_t'({load_x, {FRAC_BITS{1'b0}}});
      pos_y_d = YMaxPos <<< FRAC_BITS;
      vel_x_d = load_vx;
      vel_y_d = load_vy;
      size_d  = load_size;
    end else if (exits) begin
      pos_x_d = '0;
      pos_y_d = '0;
      vel_x_d = '0;
      vel_y_d = '0;
      size_d  = '0;
    end else if (stepping) begin
      pos_x_d = x_step;
      pos_y_d = y_step;
      vel_y_d = vy_step;
    end
  end

  // Slot state registers with synchronous reset.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q <= StFree;
      pos_x_q <= '0;
      pos_y_q <= '0;
      vel_x_q <= '0;
      vel_y_q <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_x_q <= vel_x_d;
      vel_y_q <= vel_y_d;
      size_q  <= size_d;
    end
  end

  assign active = (state_q != StFree);
  assign sliced = (state_q == StSliced);
  assign x_pix  = pix_clamp(pos_x_q, PIX_W'(X_MAX));
  assign y_pix  = pix_clamp(pos_y_q, PIX_W'(Y_MAX));
  assign size   = size_q;

endmodule

// File: rtl/fruit_engine.sv
// Multi-fruit physics engine: slot allocation, cut/miss accounting, level and game over.
module fruit_engine
  import fruit_pkg::*;
#(
  parameter int unsigned NUM_FRUITS = 4
) (
  input  logic                        frame_clk,
  input  logic                        Reset_n,
  input  logic                        step,
  input  logic                        spawn_valid,
  output logic                        spawn_ready,
  input  logic [PIX_W-1:0]            spawn_x,
  input  logic signed [VEL_W-1:0]     spawn_vx,
  input  logic signed [VEL_W-1:0]     spawn_vy,
  input  logic [PIX_W-1:0]            spawn_size,
  input  logic [NUM_FRUITS-1:0]       cut_mask,
  output logic [NUM_FRUITS*PIX_W-1:0] fruit_x,
  output logic [NUM_FRUITS*PIX_W-1:0] fruit_y,
  output logic [NUM_FRUITS*PIX_W-1:0] fruit_s,
  output logic [NUM_FRUITS-1:0]       active_mask,
  output logic [NUM_FRUITS-1:0]       sliced_mask,
  output logic                        miss_pulse,
  output logic [CNT_W-1:0]            cut_count,
  output logic [CNT_W-1:0]            miss_count,
  output logic [2:0]                  level,
  output logic                        game_over
);

  logic [NUM_FRUITS-1:0] alloc, slot_cut, slot_miss;
  logic [CNT_W-1:0] cut_cnt_q, cut_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] cut_inc, miss_inc, lvl_raw;
  logic [CNT_W:0] cut_sum, miss_sum;
  logic miss_pulse_q, spawn_fire, step_en;
  logic [GRAV_W-1:0] gravity;

  // Ready depends only on registered state, so a slot freed this edge is reused next cycle.
  assign game_over   = (miss_cnt_q >= CNT_W'(MAX_MISSES));
  assign spawn_ready = Reset_n && !(&active_mask) && !game_over;
  assign spawn_fire  = spawn_valid && spawn_ready;
  assign step_en     = step && !game_over;

  // Lowest-index free slot wins: scan high to low so the last hit is the lowest.
  always_comb begin
    alloc = '0;
    for (int i = NUM_FRUITS - 1; i >= 0; i--) begin
      if (!active_mask[i]) begin
        alloc    = '0;
        alloc[i] = 1'b1;
      end
    end
  end

  // Level and the gravity it implies for the next step.
  always_comb begin
    lvl_raw = cut_cnt_q / CNT_W'(CUTS_PER_LEVEL);
    level   = (lvl_raw > CNT_W'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : lvl_raw[2:0];
    gravity = GRAV_W'(GRAV_BASE) + GRAV_W'(level) * GRAV_W'(GRAV_INC);
  end

  for (genvar i = 0; i < NUM_FRUITS; i++) begin : g_slot
    fruit_slot u_slot (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .load      (alloc[i] && spawn_fire),
      .load_x    (spawn_x),
      .load_vx   (spawn_vx),
      .load_vy   (spawn_vy),
      .load_size (spawn_size),
      .step_en   (step_en),
      .cut       (cut_mask[i]),
      .gravity   (gravity),
      .active    (active_mask[i]),
      .sliced    (sliced_mask[i]),
      .cut_hit   (slot_cut[i]),
      .miss      (slot_miss[i]),
      .x_pix     (fruit_x[PIX_W*i +: PIX_W]),
      .y_pix     (fruit_y[PIX_W*i +: PIX_W]),
      .size      (fruit_s[PIX_W*i +: PIX_W])
    );
  end

  // Popcount of accepted cuts and misses, added into saturating counters.
  always_comb begin
    cut_inc  = '0;
    miss_inc = '0;
    for (int i = 0; i < NUM_FRUITS; i++) begin
      cut_inc  = cut_inc + CNT_W'(slot_cut[i]);
      miss_inc = miss_inc + CNT_W'(slot_miss[i]);
    end
    cut_sum    = {1'b0, cut_cnt_q} + {1'b0, cut_inc};
    miss_sum   = {1'b0, miss_cnt_q} + {1'b0, miss_inc};
    cut_cnt_d  = cut_sum[CNT_W] ? '1 : cut_sum[CNT_W-1:0];
    miss_cnt_d = miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
  end

  // Counter and miss pulse registers with synchronous reset.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      cut_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      miss_pulse_q <= 1'b0;
    end else begin
      cut_cnt_q    <= cut_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      miss_pulse_q <= |slot_miss;
    end
  end

  assign cut_count  = cut_cnt_q;
  assign miss_count = miss_cnt_q;
  assign miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_fruit_engine.sv
// Self-checking bench for fruit_engine: directed scenarios plus random traffic vs a slot model.
module tb_fruit_engine;

  localparam int NF = 4;

  logic              frame_clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              step = 1'b0;
  logic              spawn_valid = 1'b0;
  logic              spawn_ready;
  logic [9:0]        spawn_x = '0;
  logic signed [11:0] spawn_vx = '0;
  logic signed [11:0] spawn_vy = '0;
  logic [9:0]        spawn_size = '0;
  logic [NF-1:0]     cut_mask = '0;
  logic [NF*10-1:0]  fruit_x, fruit_y, fruit_s;
  logic [NF-1:0]     active_mask, sliced_mask;
  logic              miss_pulse, game_over;
  logic [7:0]        cut_count, miss_count;
  logic [2:0]        level;

  always #5 frame_clk = ~frame_clk;

  fruit_engine #(.NUM_FRUITS(NF)) dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .step        (step),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .spawn_x     (spawn_x),
    .spawn_vx    (spawn_vx),
    .spawn_vy    (spawn_vy),
    .spawn_size  (spawn_size),
    .cut_mask    (cut_mask),
    .fruit_x     (fruit_x),
    .fruit_y     (fruit_y),
    .fruit_s     (fruit_s),
    .active_mask (active_mask),
    .sliced_mask (sliced_mask),
    .miss_pulse  (miss_pulse),
    .cut_count   (cut_count),
    .miss_count  (miss_count),
    .level       (level),
    .game_over   (game_over)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: slot state 0 = free, 1 = flying, 2 = sliced; positions in 1/16 px.
  int m_st[NF], m_px[NF], m_py[NF], m_vx[NF], m_vy[NF], m_sz[NF];
  int m_cuts, m_misses;
  bit m_pulse;

  function automatic int clip(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int m_level();
    return clip(m_cuts / 5, 0, 7);
  endfunction

  function automatic bit m_over();
    return m_misses >= 3;
  endfunction

  function automatic bit m_ready();
    if (m_over()) return 1'b0;
    for (int i = 0; i < NF; i++) if (m_st[i] == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_st[i] = 0; m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_sz[i] = 0;
    end
    m_cuts = 0; m_misses = 0; m_pulse = 0;
  endtask

  task automatic model_edge(input bit v, input int x, input int vx, input int vy, input int sz,
                            input bit st, input logic [NF-1:0] cm);
    int slot, g, nc, nm, nx, ny;
    bit stepping, hit, gone;
    slot = -1;
    if (v && m_ready())
      for (int i = 0; i < NF; i++) if (slot < 0 && m_st[i] == 0) slot = i;
    stepping = st && !m_over();
    g  = 2 + m_level();
    nc = 0;
    nm = 0;
    for (int i = 0; i < NF; i++) begin
      if (i == slot) begin
        m_st[i] = 1; m_px[i] = x * 16; m_py[i] = 479 * 16;
        m_vx[i] = vx; m_vy[i] = vy; m_sz[i] = sz;
      end else if (m_st[i] != 0) begin
        hit = cm[i] && (m_st[i] == 1);
        if (hit) nc++;
        gone = 1'b0;
        if (stepping) begin
          nx = clip(m_px[i] + m_vx[i], -16384, 16383);
          ny = clip(m_py[i] + m_vy[i], -16384, 16383);
          gone = (nx < 0) || ((nx >>> 4) > 639) || (((ny >>> 4) > 479) && (m_vy[i] > 0));
          if (gone) begin
            if (m_st[i] == 1 && !hit) nm++;
            m_st[i] = 0; m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_sz[i] = 0;
          end else begin
            m_px[i] = nx;
            m_py[i] = ny;
            m_vy[i] = clip(m_vy[i] + g, -2048, 2047);
          end
        end
        if (hit && !gone) m_st[i] = 2;
      end
    end
    m_cuts   = clip(m_cuts + nc, 0, 255);
    m_misses = clip(m_misses + nm, 0, 255);
    m_pulse  = (nm > 0);
  endtask

  task automatic compare_outputs();
    logic [NF*10-1:0] ex, ey, es;
    logic [NF-1:0] ea, esl;
    for (int i = 0; i < NF; i++) begin
      ex[10*i +: 10] = 10'(m_px[i] >>> 4);
      ey[10*i +: 10] = 10'(clip(m_py[i] >>> 4, 0, 479));
      es[10*i +: 10] = 10'(m_sz[i]);
      ea[i]  = (m_st[i] != 0);
      esl[i] = (m_st[i] == 2);
    end
    check_val("fruit_x", fruit_x, ex);
    check_val("fruit_y", fruit_y, ey);
    check_val("fruit_s", fruit_s, es);
    check_val("active_mask", active_mask, ea);
    check_val("sliced_mask", sliced_mask, esl);
    check_val("miss_pulse", miss_pulse, m_pulse);
    check_val("cut_count", cut_count, m_cuts);
    check_val("miss_count", miss_count, m_misses);
    check_val("level", level, m_level());
    check_val("game_over", game_over, m_over());
  endtask

  // One frame: drive inputs, check ready, clock, advance model, check outputs.
  task automatic tick(input bit v, input int x, input int vx, input int vy, input int sz,
                      input bit st, input logic [NF-1:0] cm);
    spawn_valid = v;
    spawn_x     = 10'(x);
    spawn_vx    = 12'(vx);
    spawn_vy    = 12'(vy);
    spawn_size  = 10'(sz);
    step        = st;
    cut_mask    = cm;
    #1;
    check_val("spawn_ready", spawn_ready, m_ready());
    @(posedge frame_clk);
    model_edge(v, x, vx, vy, sz, st, cm);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset(input int cycles);
    Reset_n     = 1'b0;
    spawn_valid = 1'b0;
    step        = 1'b0;
    cut_mask    = '0;
    repeat (cycles) begin
      #1;
      check_val("ready_in_reset", spawn_ready, 1'b0);
      @(posedge frame_clk);
      model_reset();
      #1;
      compare_outputs();
    end
    Reset_n = 1'b1;
  endtask

  int cnt, pulses, over_cycles;
  bit v;
  int vy;

  initial begin
    // Reset and first spawn with one step.
    do_reset(2);
    tick(0, 0, 0, 0, 0, 0, '0);
    check_val("ready_after_reset", spawn_ready, 1'b1);
    tick(1, 100, 16, -160, 8, 0, '0);
    tick(0, 0, 0, 0, 0, 1, '0);
    check_val("s0_x_step", fruit_x[9:0], 101);
    check_val("s0_y_step", fruit_y[9:0], 469);
    check_val("s0_active", active_mask, 4'b0001);

    // Fill all slots; slot2 is fast and leaves on the next step.
    tick(1, 200, 0, -100, 5, 0, '0);
    tick(1, 630, 320, -100, 6, 0, '0);
    tick(1, 300, 0, -100, 7, 0, '0);
    tick(1, 50, 0, -100, 9, 0, '0);
    check_val("full_active", active_mask, 4'b1111);
    tick(0, 0, 0, 0, 0, 1, 4'b0100);
    check_val("s2_gone", active_mask, 4'b1011);
    check_val("s2_no_miss", miss_count, 0);
    tick(1, 400, 0, -50, 9, 0, '0);
    check_val("reuse_s2", fruit_x[29:20], 400);
    tick(0, 0, 0, 0, 0, 0, 4'b0001);
    check_val("cut_s0", sliced_mask, 4'b0001);
    tick(0, 0, 0, 0, 0, 0, 4'b0001);
    check_val("recut_s0", cut_count, 2);

    // Miss sequence: a long-flight fruit in slot0, short hops in slot1 until game over.
    do_reset(1);
    tick(1, 320, 0, -300, 4, 0, '0);
    for (int k = 0; k < 3; k++) begin
      tick(1, 320, 0, -16, 4, 0, '0);
      pulses = 0;
      cnt = 0;
      while (active_mask[1] && cnt < 200) begin
        tick(0, 0, 0, 0, 0, 1, '0);
        pulses += int'(miss_pulse);
        cnt++;
      end
      check_val("exit_in_time", cnt < 200, 1'b1);
      tick(0, 0, 0, 0, 0, 0, '0);
      pulses += int'(miss_pulse);
      check_val("one_pulse", pulses, 1);
    end
    check_val("go_set", game_over, 1'b1);
    check_val("go_misses", miss_count, 3);
    tick(1, 10, 0, -16, 4, 1, '0);
    check_val("go_no_spawn", active_mask, 4'b0001);
    tick(0, 0, 0, 0, 0, 1, 4'b0001);
    check_val("go_cut_ok", cut_count, 1);

    // Level progression and gravity at level 1.
    do_reset(1);
    for (int k = 0; k < 40; k++) begin
      tick(1, 630, 320, 0, 4, 0, '0);
      tick(0, 0, 0, 0, 0, 1, 4'b1111);
      if (k == 4) begin
        check_val("level_1", level, 1);
        tick(1, 100, 0, -160, 8, 0, '0);
        for (int s = 0; s < 8; s++) tick(0, 0, 0, 0, 0, 1, '0);
        check_val("grav_level1", fruit_y[9:0], (7664 - 8 * 160 + 3 * 28) / 16);
      end
    end
    check_val("level_sat", level, 7);
    check_val("cuts_40", cut_count >= 8'd40, 1'b1);

    // Random traffic.
    do_reset(2);
    over_cycles = 0;
    for (int c = 0; c < 4000; c++) begin
      v  = ($urandom_range(0, 1) == 1);
      vy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                       : -int'($urandom_range(16, 300));
      tick(v, int'($urandom_range(0, 639)), int'($urandom_range(0, 128)) - 64, vy,
           int'($urandom_range(0, 1023)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0) ? NF'($urandom) : '0);
      over_cycles = m_over() ? over_cycles + 1 : 0;
      if (over_cycles > 30 || $urandom_range(0, 499) == 0) begin
        do_reset(1);
        over_cycles = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fruit_engine.md
Name: fruit_engine

Overview:
Multi-fruit physics engine. It is the parametrised successor of the single-fruit mover. It owns NUM_FRUITS independent fruit slots and handles spawning through a valid/ready handshake. On each step it applies fixed-point ballistic motion with gravity that rises with difficulty level, marks fruit as sliced, and detects off-screen misses. It sits between the spawn/RNG logic and slice-detection logic on one side and the sprite renderer and score display on the other.

Parameters:
NUM_FRUITS, 4, number of fruit slots
FRAC_BITS, 4, fractional bits of position and velocity (1/16 px)
VEL_W, 12, signed velocity width, including FRAC_BITS
GRAV_BASE, 2, gravity at level 0, in 1/2^FRAC_BITS px/step²
GRAV_INC, 1, gravity added per level
CUTS_PER_LEVEL, 5, cuts needed per level increment
MAX_LEVEL, 7, level saturation value
MAX_MISSES, 3, miss count at which game_over asserts
X_MAX, 639, rightmost pixel
Y_MAX, 479, bottom pixel; spawn row

Ports:
frame_clk  in  1  clock; all logic on rising edge
Reset_n  in  1  synchronous, active-low reset
step  in  1  advance physics one frame when high
spawn_valid  in  1  spawn request
spawn_ready  out  1  a free slot exists and not game_over
spawn_x  in  10  initial x pixel
spawn_vx  in  VEL_W  signed initial x velocity, fixed-point
spawn_vy  in  VEL_W  signed initial y velocity; negative = upward
spawn_size  in  10  fruit radius in px
cut_mask  in  NUM_FRUITS  slice request per slot
fruit_x  out  NUM_FRUITS*10  integer x per slot, slot i at [10i+9:10i]
fruit_y  out  NUM_FRUITS*10  integer y per slot, clamped to 0..Y_MAX
fruit_s  out  NUM_FRUITS*10  size per slot
active_mask  out  NUM_FRUITS  slot FLYING or SLICED
sliced_mask  out  NUM_FRUITS  slot SLICED
miss_pulse  out  1  one-cycle pulse when ≥1 FLYING fruit exits this cycle
cut_count  out  8  saturating count of cuts
miss_count  out  8  saturating count of missed fruit
level  out  3  min(cut_count/CUTS_PER_LEVEL, MAX_LEVEL)
game_over  out  1  miss_count ≥ MAX_MISSES; sticky until reset

Behaviour:
- Reset (Reset_n=0 at an edge): all slots FREE; all positions, velocities, sizes = 0; counters, level, miss_pulse and game_over = 0. spawn_ready = 0 while Reset_n is low.
- Per-slot FSM: FREE -> FLYING on spawn accept. FLYING -> SLICED on cut. FLYING -> FREE on exit (counts a miss). SLICED -> FREE on exit (no miss).
- Internal position: signed (11+FRAC_BITS) bits. Output = integer part. y below 0 is output as 0. Fruit may rise above the screen top without exiting.
- Spawn: handshake completes when spawn_valid and spawn_ready are high at an edge. The lowest-index FREE slot is loaded with x=spawn_x<<FRAC_BITS, y=Y_MAX<<FRAC_BITS, vx, vy and size. Zero latency: active_mask updates the next cycle. spawn_ready derives only from registered state, so a slot freed this cycle is not reusable until the next cycle.
- Step, for non-FREE slots not spawned this cycle: pos_next = pos + vel using the old velocity. vy_next = vy + GRAV_BASE + level*GRAV_INC. vx is constant. Velocity saturates at VEL_W limits.
- Exit test on pos_next: x<0, or x>X_MAX, or (y>Y_MAX and vy>0). On exit the slot goes FREE and its outputs are zeroed next cycle.
- Cut: evaluated against current state. Each FLYING slot set in cut_mask goes SLICED, and cut_count increases by the number of such slots. Bits for FREE or SLICED slots are ignored.
- Same-cycle cut + step: the cut slot steps normally. A cut slot that exits in the same cycle is not a miss.
- Multiple simultaneous misses: miss_count increases by the number of exits, and miss_pulse is a single pulse.
- When game_over is set: spawn_ready=0 and step is ignored, so positions freeze. cut_mask is still honoured.
- Counters saturate at 255. Level is recomputed combinationally from cut_count and takes effect on the next step.

Decomposition:
- Shared package fruit_pkg: slot_state_t enum (FREE, FLYING, SLICED), POS_W/VEL_W/FRAC_BITS constants, screen limits, and a pixel-extract/clamp function.
- Sub-module fruit_slot: one instance per slot holding the FSM, position/velocity registers, step arithmetic and exit detect.
- Top level: allocation priority encoder, cut and miss popcount, counters, level, game_over.

Test Plan:
- Reset held 2 cycles, then released -> all masks/counters 0; spawn_ready=1 on the first cycle after release.
- Spawn x=100, vx=16, vy=-160, size=8, then one step -> slot0 fruit_x=101, fruit_y=469, vy internal=-158; active_mask=0001.
- Four spawns accepted, then a fifth with spawn_valid=1 -> spawn_ready=0, no state change; cut slot2 and let it exit -> the next spawn lands in slot2.
- cut_mask=0001 on FLYING slot0 -> sliced_mask=0001, cut_count=1; repeat cut_mask=0001 -> cut_count stays 1; slot0 exits -> miss_count=0.
- Spawn with vy=-16 and run steps until it falls past 479 -> miss_pulse for exactly 1 cycle, miss_count=1, slot freed; repeat 3 times -> game_over=1, spawn_ready=0, step ignored.
- Five cuts -> level=1; the next step adds gravity 3 to vy, not 2; 40 cuts -> level stays at 7.
